// File: rtl/dmem_port_initiator_if.sv
// Bus bundle between the CPU datapath, the load/store initiator and one
// port of the data RAM. The initiator uses the slave modport; the
// requester/RAM side (CPU datapath or testbench) uses the master modport.
interface dmem_port_initiator_if #(
    parameter int AWIDTH = 14,
    parameter int DWIDTH = 32
);
    // request channel
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [AWIDTH+1:0]     req_addr;
    logic [DWIDTH-1:0]     req_wdata;
    // response channel
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DWIDTH-1:0]     resp_rdata;
    logic                  resp_err;
    // RAM port
    logic [AWIDTH-1:0]     mem_addr;
    logic [DWIDTH-1:0]     mem_d;
    logic                  mem_wen;
    logic [DWIDTH/8-1:0]   mem_wbe;
    logic [DWIDTH-1:0]     mem_q;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  resp_ready, mem_q,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_d, mem_wen, mem_wbe
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output resp_ready, mem_q,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_d, mem_wen, mem_wbe
    );
endinterface

// File: rtl/dmem_port_initiator.sv
// Single-outstanding load/store initiator for one data RAM port.
// IDLE accepts a request, ACCESS drives the RAM for one cycle, RESP holds
// the response until it is taken. All outputs come straight from flops.
module dmem_port_initiator #(
    parameter int AWIDTH = 14,
    parameter int DWIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dmem_port_initiator_if.slave  bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]          r_state;
    logic                r_req_ready;
    logic                r_resp_valid;
    logic                r_resp_err;
    logic [DWIDTH-1:0]   r_resp_rdata;
    logic [AWIDTH-1:0]   r_mem_addr;
    logic [DWIDTH-1:0]   r_mem_d;
    logic                r_mem_wen;
    logic [3:0]          r_mem_wbe;
    // request fields needed again when the load data comes back
    logic                r_we;
    logic [1:0]          r_size;
    logic                r_unsigned;
    logic [1:0]          r_b;

    logic [1:0]          w_b;
    logic                w_legal;
    logic [3:0]          w_wbe;
    logic [DWIDTH-1:0]   w_d;
    logic [DWIDTH-1:0]   w_shift;
    logic [DWIDTH-1:0]   w_ext;

    assign w_b = bus.req_addr[1:0];

    // Size 11 is illegal; halves need even, words need 4-aligned addresses.
    assign w_legal = (bus.req_size != 2'b11) &&
                     !(bus.req_size == 2'b01 && w_b[0]) &&
                     !(bus.req_size == 2'b10 && w_b != 2'b00);

    // Store lane replication and byte enables for the incoming request.
    always_comb begin
        w_wbe = 4'b0000;
        w_d   = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                w_wbe = 4'b0001 << w_b;
                w_d   = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                w_wbe = 4'b0011 << w_b;
                w_d   = {2{bus.req_wdata[15:0]}};
            end
            2'b10: w_wbe = 4'b1111;
            default: w_wbe = 4'b0000;
        endcase
        if (!bus.req_we)
            w_wbe = 4'b0000;
    end

    assign w_shift = bus.mem_q >> {r_b, 3'b000};

    // Right-justify and extend the addressed byte/half of the RAM word.
    always_comb begin
        w_ext = w_shift;
        case (r_size)
            2'b00: w_ext = r_unsigned ? {24'b0, w_shift[7:0]}
                                      : {{24{w_shift[7]}}, w_shift[7:0]};
            2'b01: w_ext = r_unsigned ? {16'b0, w_shift[15:0]}
                                      : {{16{w_shift[15]}}, w_shift[15:0]};
            default: w_ext = w_shift;
        endcase
    end

    // Request/access/response sequencing; reset clears mem_wen at once so an
    // in-flight store can never complete a partial write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_mem_addr   <= '0;
            r_mem_d      <= '0;
            r_mem_wen    <= 1'b0;
            r_mem_wbe    <= 4'b0000;
            r_we         <= 1'b0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_b          <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_we        <= bus.req_we;
                        r_size      <= bus.req_size;
                        r_unsigned  <= bus.req_unsigned;
                        r_b         <= w_b;
                        if (w_legal) begin
                            r_state    <= S_ACCESS;
                            r_mem_addr <= bus.req_addr[AWIDTH+1:2];
                            r_mem_d    <= w_d;
                            r_mem_wbe  <= w_wbe;
                            r_mem_wen  <= bus.req_we;
                        end else begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end
                    end
                end
                S_ACCESS: begin
                    r_state      <= S_RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= r_we ? '0 : w_ext;
                    r_mem_wen    <= 1'b0;
                    r_mem_wbe    <= 4'b0000;
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_d      = r_mem_d;
    assign bus.mem_wen    = r_mem_wen;
    assign bus.mem_wbe    = r_mem_wbe;
endmodule
